// File: rtl/suma_pkg.sv
// Shared key codes, FSM state type and key helpers for the keypad-to-adder sequencer.
package suma_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_ADD   = 4'd10;
  localparam key_code_t KEY_EQUAL = 4'd11;
  localparam key_code_t KEY_CLEAR = 4'd12;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    LOAD,
    GAP
  } seq_state_t;

  // Codes 13..15 are consumed silently and never reach the adder.
  function automatic logic is_valid_key(input key_code_t code);
    return code <= KEY_CLEAR;
  endfunction

  function automatic logic needs_result(input key_code_t code);
    return (code == KEY_ADD) || (code == KEY_EQUAL);
  endfunction

endpackage

// File: rtl/suma_sequencer_key_fifo.sv
// Small key FIFO: power-of-two depth, wrapping pointers, DEPTH+1-state occupancy count.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/suma_sequencer.sv
// Keypad-to-adder sequencer: queues key events, paces them to the adder, loads results to display.
// Optional build macro SEQ_TIMEOUT_EN adds a bounded wait for the adder's result pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | nothing in flight, waiting for a queued key
// ISSUE    | pop FIFO head, strobe it to the adder on the next cycle
// WAIT_RES | ADD/EQUAL issued, waiting for the adder's result pulse
// LOAD     | push captured value (and error) into the display path
// GAP      | enforced quiet time before the next key may issue
module suma_sequencer
  import suma_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int RESULT_WIDTH   = 14,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    kp_valid,
  input  logic [3:0]              kp_code,
  output logic                    kp_ready,
  output logic [3:0]              add_key_code,
  output logic                    add_key_pulse,
  input  logic [RESULT_WIDTH-1:0] add_result,
  input  logic                    add_result_pulse,
  input  logic                    add_overflow,
  output logic [RESULT_WIDTH-1:0] disp_value,
  output logic                    disp_load,
  output logic                    disp_err,
  output logic                    busy
);

  // GAP lasts GAP_CYCLES clocks, giving GAP_CYCLES+2 clocks between digit pulses.
  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  seq_state_t              state;
  seq_state_t              state_nxt;
  key_code_t               head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [GAP_W-1:0]        gap_cnt;
  logic [RESULT_WIDTH-1:0] cap_value;
  logic                    cap_ovf;

`ifdef SEQ_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  assign kp_ready  = !fifo_full;
  assign fifo_push = kp_valid && kp_ready;
  assign busy      = (state != IDLE) || !fifo_empty;

  key_fifo #(
    .WIDTH(4),
    .DEPTH(FIFO_DEPTH)
  ) u_key_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (kp_code),
    .pop  (fifo_pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) state_nxt = ISSUE;
      ISSUE: begin
        fifo_pop = 1'b1;
        if (needs_result(head))     state_nxt = WAIT_RES;
        else if (head == KEY_CLEAR) state_nxt = LOAD;
        else                        state_nxt = GAP;
      end
      WAIT_RES: begin
        if (add_result_pulse) state_nxt = LOAD;
`ifdef SEQ_TIMEOUT_EN
        else if (tmo_cnt == '0) state_nxt = LOAD;
`endif
      end
      LOAD:    state_nxt = GAP;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_key_code  <= '0;
      add_key_pulse <= 1'b0;
      disp_value    <= '0;
      disp_load     <= 1'b0;
      disp_err      <= 1'b0;
      cap_value     <= '0;
      cap_ovf       <= 1'b0;
      gap_cnt       <= '0;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      add_key_pulse <= 1'b0;
      disp_load     <= 1'b0;
      case (state)
        ISSUE: begin
          if (is_valid_key(head)) begin
            add_key_pulse <= 1'b1;
            add_key_code  <= head;
          end
          if (head == KEY_CLEAR) begin
            cap_value <= '0;
            cap_ovf   <= 1'b0;
            disp_err  <= 1'b0;
          end
          gap_cnt <= GAP_LOAD;
`ifdef SEQ_TIMEOUT_EN
          tmo_cnt <= TMO_LOAD;
`endif
        end
        WAIT_RES: begin
          if (add_result_pulse) begin
            cap_value <= add_result;
            cap_ovf   <= add_overflow;
          end
`ifdef SEQ_TIMEOUT_EN
          // Timed out: keep the displayed value, flag the error.
          else if (tmo_cnt == '0) begin
            cap_value <= disp_value;
            cap_ovf   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        LOAD: begin
          disp_value <= cap_value;
          disp_load  <= 1'b1;
          disp_err   <= disp_err | cap_ovf;
          gap_cnt    <= GAP_LOAD;
        end
        GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
